// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue sequencer: instruction opcodes/functs,
// ALU control encodings and the sequencer state type.
package alu_issue_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_ADDI  = 6'd1;
    localparam logic [5:0] OP_COMPI = 6'd2;

    localparam logic [5:0] FN_ADD  = 6'd0;
    localparam logic [5:0] FN_NOTB = 6'd1;
    localparam logic [5:0] FN_AND  = 6'd2;
    localparam logic [5:0] FN_XOR  = 6'd3;
    localparam logic [5:0] FN_SUB  = 6'd4;
    localparam logic [5:0] FN_SRL  = 6'd5;
    localparam logic [5:0] FN_SLL  = 6'd6;
    localparam logic [5:0] FN_SRA  = 6'd7;
    localparam logic [5:0] FN_SRLV = 6'd8;
    localparam logic [5:0] FN_SLLV = 6'd9;
    localparam logic [5:0] FN_SRAV = 6'd10;

    localparam logic [3:0] ALU_SUM  = 4'd0;
    localparam logic [3:0] ALU_NOTB = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_XOR  = 4'd3;
    localparam logic [3:0] ALU_DIFF = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_EXEC,
        S_WB,
        S_ERR
    } state_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-word valid/ready channel into the issue sequencer.
interface alu_issue_ctrl_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;

    modport master (output instr_valid, output instr, input instr_ready);
    modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational decode of an instruction word into ALU control, operand
// selects, destination register and an illegal-instruction flag.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [3:0]  alu_cntrl_o,
    output logic        use_imm_o,
    output logic        var_shift_o,
    output logic [4:0]  dest_o,
    output logic        illegal_o
);
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode        = instr_i[31:26];
    assign funct         = instr_i[5:0];
    assign unused_fields = &{1'b0, instr_i[25:21], instr_i[10:6]};

    always_comb begin
        alu_cntrl_o = ALU_SUM;
        use_imm_o   = 1'b0;
        var_shift_o = 1'b0;
        dest_o      = instr_i[15:11];
        illegal_o   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (funct <= FN_SRA) begin
                    alu_cntrl_o = funct[3:0];
                end else begin
                    case (funct)
                        FN_SRLV: begin var_shift_o = 1'b1; alu_cntrl_o = ALU_SRL; end
                        FN_SLLV: begin var_shift_o = 1'b1; alu_cntrl_o = ALU_SLL; end
                        FN_SRAV: begin var_shift_o = 1'b1; alu_cntrl_o = ALU_SRA; end
                        default: illegal_o = 1'b1;
                    endcase
                end
            end
            OP_ADDI: begin
                use_imm_o = 1'b1;
                dest_o    = instr_i[20:16];
            end
            OP_COMPI: begin
                alu_cntrl_o = ALU_NOTB;
                use_imm_o   = 1'b1;
                dest_o      = instr_i[20:16];
            end
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue sequencer in front of the 32-bit ALU: IDLE/READ/EXEC/WB.
// Define ISSUE_OVERLAP_EN to also accept instructions in WB and ERR.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int IMMW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_ctrl_if.slave ifc,
    output logic [AW-1:0]   rs_addr,
    output logic [AW-1:0]   rt_addr,
    input  logic [DW-1:0]   rs_data,
    input  logic [DW-1:0]   rt_data,
    output logic [DW-1:0]   alu_a,
    output logic [DW-1:0]   alu_b,
    output logic [4:0]      alu_shift,
    output logic [3:0]      alu_cntrl,
    input  logic [DW-1:0]   alu_result,
    input  logic [2:0]      alu_flag,
    output logic            wb_en,
    output logic [AW-1:0]   wb_addr,
    output logic [DW-1:0]   wb_data,
    output logic [2:0]      flags_q,
    output logic            done,
    output logic            illegal
);
`ifdef ISSUE_OVERLAP_EN
    localparam logic OVERLAP = 1'b1;
`else
    localparam logic OVERLAP = 1'b0;
`endif

    state_t          state_q, state_d;
    logic            ready_q, ready_d, accept, in_exec;
    logic [3:0]      dec_cntrl;
    logic            dec_use_imm, dec_var, dec_ill;
    logic [4:0]      dec_dest;
    logic [3:0]      cntrl_q, alu_cntrl_q;
    logic            use_imm_q, var_q, wb_en_q, done_q, illegal_q;
    logic [AW-1:0]   dest_q, rs_addr_q, rt_addr_q, wb_addr_q;
    logic [IMMW-1:0] imm_q;
    logic [DW-1:0]   res_q, alu_a_q, alu_b_q, imm_ext, exec_b;
    logic [4:0]      alu_shift_q, exec_shift;
    logic [2:0]      flag_n_q;

    alu_issue_decode u_decode (
        .instr_i     (ifc.instr),
        .alu_cntrl_o (dec_cntrl),
        .use_imm_o   (dec_use_imm),
        .var_shift_o (dec_var),
        .dest_o      (dec_dest),
        .illegal_o   (dec_ill)
    );

    assign accept     = ifc.instr_valid && ready_q;
    assign in_exec    = (state_q == S_EXEC);
    assign imm_ext    = {{(DW-IMMW){imm_q[IMMW-1]}}, imm_q};
    assign exec_b     = use_imm_q ? imm_ext : rt_data;
    assign exec_shift = var_q ? rt_data[4:0] : imm_q[10:6];

    // ALU operands are live only in EXEC (regfile data arrives then) and held otherwise
    assign alu_a     = in_exec ? rs_data    : alu_a_q;
    assign alu_b     = in_exec ? exec_b     : alu_b_q;
    assign alu_shift = in_exec ? exec_shift : alu_shift_q;
    assign alu_cntrl = in_exec ? cntrl_q    : alu_cntrl_q;

    assign ifc.instr_ready = ready_q;
    assign rs_addr = rs_addr_q;
    assign rt_addr = rt_addr_q;
    assign wb_en   = wb_en_q;
    assign wb_addr = wb_addr_q;
    assign wb_data = res_q;
    assign done    = done_q;
    assign illegal = illegal_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = dec_ill ? S_ERR : S_READ;
            S_READ:      state_d = S_EXEC;
            S_EXEC:      state_d = S_WB;
            S_WB, S_ERR: state_d = accept ? (dec_ill ? S_ERR : S_READ) : S_IDLE;
            default:     state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE) ||
                  (OVERLAP && ((state_d == S_WB) || (state_d == S_ERR)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            cntrl_q     <= '0;
            use_imm_q   <= 1'b0;
            var_q       <= 1'b0;
            dest_q      <= '0;
            imm_q       <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_shift_q <= '0;
            alu_cntrl_q <= '0;
            res_q       <= '0;
            flag_n_q    <= '0;
            flags_q     <= '0;
            wb_en_q     <= 1'b0;
            wb_addr_q   <= '0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            wb_en_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (accept) begin
                cntrl_q   <= dec_cntrl;
                use_imm_q <= dec_use_imm;
                var_q     <= dec_var;
                dest_q    <= dec_dest;
                imm_q     <= ifc.instr[IMMW-1:0];
                rs_addr_q <= ifc.instr[25:21];
                rt_addr_q <= ifc.instr[20:16];
                illegal_q <= dec_ill;
            end
            if (in_exec) begin
                alu_a_q     <= rs_data;
                alu_b_q     <= exec_b;
                alu_shift_q <= exec_shift;
                alu_cntrl_q <= cntrl_q;
                res_q       <= alu_result;
                flag_n_q    <= alu_flag;
                wb_en_q     <= (dest_q != '0);
                wb_addr_q   <= dest_q;
                done_q      <= 1'b1;
            end
            // Flags become architectural only once the instruction retires
            if (state_q == S_WB) flags_q <= flag_n_q;
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural regfile and ALU.
`timescale 1ns/1ps
module tb_alu_issue_ctrl;
    import alu_issue_pkg::*;

    typedef struct {
        logic        wb;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  cntrl;
        logic [4:0]  shift;
        logic        chk_shift;
        logic [2:0]  flags;
        logic        ill;
    } exp_t;

`ifdef ISSUE_OVERLAP_EN
    localparam int GAP = 3;
`else
    localparam int GAP = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs_addr, rt_addr, wb_addr, alu_shift;
    logic [31:0] rs_data, rt_data, alu_a, alu_b, alu_result, wb_data;
    logic [3:0]  alu_cntrl;
    logic [2:0]  alu_flag, flags_q;
    logic        wb_en, done, illegal;
    logic        pre_we = 1'b0;
    logic [4:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;
    logic [31:0] regs [32];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        sb [$];
    int          xq [$];

    always #5 clk = ~clk;

    alu_issue_ctrl_if ifc ();

    alu_issue_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ifc        (ifc),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_shift  (alu_shift),
        .alu_cntrl  (alu_cntrl),
        .alu_result (alu_result),
        .alu_flag   (alu_flag),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flags_q    (flags_q),
        .done       (done),
        .illegal    (illegal)
    );

    // ALU model: flags are {a sign, a zero, adder carry}
    always_comb begin
        logic c;
        c = 1'b0;
        alu_result = '0;
        case (alu_cntrl)
            4'd0: {c, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
            4'd1: alu_result = 32'd0 - alu_b;
            4'd2: alu_result = alu_a & alu_b;
            4'd3: alu_result = alu_a ^ alu_b;
            4'd4: alu_result = alu_a - alu_b;
            4'd5: alu_result = alu_a >> alu_shift;
            4'd6: alu_result = alu_a << alu_shift;
            4'd7: alu_result = $signed(alu_a) >>> alu_shift;
            default: alu_result = '0;
        endcase
        alu_flag = {alu_a[31], (alu_a == 32'd0), c};
    end

    always @(posedge clk) begin
        if (pre_we) regs[pre_addr] <= pre_data;
        else if (wb_en && wb_addr != 5'd0) regs[wb_addr] <= wb_data;
        rs_data <= (rs_addr == 5'd0) ? 32'd0 : regs[rs_addr];
        rt_data <= (rt_addr == 5'd0) ? 32'd0 : regs[rt_addr];
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t ex(input logic wb, input logic [4:0] addr, input logic [31:0] data,
                                input logic [3:0] cntrl, input logic [4:0] shift,
                                input logic cs, input logic [2:0] flags, input logic ill);
        exp_t e;
        e.wb = wb; e.addr = addr; e.data = data; e.cntrl = cntrl;
        e.shift = shift; e.chk_shift = cs; e.flags = flags; e.ill = ill;
        return e;
    endfunction

    // Monitor: pops the scoreboard whenever the DUT retires or flags illegal
    initial begin : monitor
        exp_t e;
        int   t;
        bit   fpend;
        bit   fill;
        logic [2:0] fexp;
        fpend = 0; fill = 0; fexp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                xq.delete();
                fpend = 0;
            end else begin
                if (fpend) begin
                    chk("flags_q", {29'd0, flags_q}, {29'd0, fexp});
                    if (fill) begin
                        chk("illegal_one_cycle", {31'd0, illegal}, 32'd0);
                        chk("ready_after_err", {31'd0, ifc.instr_ready}, 32'd1);
                    end else begin
                        chk("done_one_cycle", {31'd0, done}, 32'd0);
                    end
                    fpend = 0;
                end
                if (ifc.instr_valid && ifc.instr_ready) xq.push_back(cyc);
                if (done || illegal || wb_en) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", {29'd0, done, illegal, wb_en}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        t = (xq.size() > 0) ? xq.pop_front() : -1000;
                        chk("latency", cyc - t, e.ill ? 32'd1 : 32'd3);
                        if (e.ill) begin
                            chk("illegal", {31'd0, illegal}, 32'd1);
                            chk("err_wb_en", {31'd0, wb_en}, 32'd0);
                            chk("err_done", {31'd0, done}, 32'd0);
                        end else begin
                            chk("done", {31'd0, done}, 32'd1);
                            chk("wb_en", {31'd0, wb_en}, {31'd0, e.wb});
                            if (e.wb) chk("wb_addr", {27'd0, wb_addr}, {27'd0, e.addr});
                            chk("wb_data", wb_data, e.data);
                            chk("alu_cntrl", {28'd0, alu_cntrl}, {28'd0, e.cntrl});
                            if (e.chk_shift) chk("alu_shift", {27'd0, alu_shift}, {27'd0, e.shift});
                        end
                        fpend = 1; fill = e.ill; fexp = e.flags;
                    end
                end
            end
        end
    end

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w, input exp_t e, input bit push);
        int n;
        n = 0;
        ifc.instr = w;
        ifc.instr_valid = 1'b1;
        @(negedge clk);
        while (!ifc.instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ifc.instr_ready) chk("ready_timeout", 32'd0, 32'd1);
        if (push) sb.push_back(e);
        @(posedge clk); #1;
        ifc.instr_valid = 1'b0;
        chk("ready_busy", {31'd0, ifc.instr_ready}, 32'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_ready"},   {31'd0, ifc.instr_ready}, 32'd1);
        chk({tag, "_wb_en"},   {31'd0, wb_en}, 32'd0);
        chk({tag, "_done"},    {31'd0, done}, 32'd0);
        chk({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
        chk({tag, "_flags"},   {29'd0, flags_q}, 32'd0);
        chk({tag, "_rs_addr"}, {27'd0, rs_addr}, 32'd0);
        chk({tag, "_alu_a"},   alu_a, 32'd0);
        chk({tag, "_alu_cntrl"}, {28'd0, alu_cntrl}, 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int t0, t1, t2;
        exp_t none;
        none = ex(0, 0, 0, 0, 0, 0, 0, 0);
        ifc.instr_valid = 1'b0;
        ifc.instr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        preload(1, 32'd5); preload(2, 32'd7);
        issue(rtype(1, 2, 3, 0, FN_ADD), ex(1, 3, 32'd12, ALU_SUM, 0, 0, 3'b000, 0), 1);
        drain();

        issue(itype(OP_ADDI, 0, 4, 16'hFFFF), ex(1, 4, 32'hFFFFFFFF, ALU_SUM, 0, 0, 3'b010, 0), 1);
        drain();
        issue(itype(OP_COMPI, 0, 5, 16'h0003), ex(1, 5, 32'hFFFFFFFD, ALU_NOTB, 0, 0, 3'b010, 0), 1);
        drain();

        preload(1, 32'h80000000);
        issue(rtype(1, 0, 6, 4, FN_SRA), ex(1, 6, 32'hF8000000, ALU_SRA, 5'd4, 1, 3'b100, 0), 1);
        drain();
        preload(1, 32'd3); preload(2, 32'd33);
        issue(rtype(1, 2, 7, 0, FN_SLLV), ex(1, 7, 32'd6, ALU_SLL, 5'd1, 1, 3'b000, 0), 1);
        drain();
        chk("regfile_r7", regs[7], 32'd6);

        preload(1, 32'hFFFFFFFF); preload(2, 32'd1);
        issue(rtype(1, 2, 8, 0, FN_ADD), ex(1, 8, 32'd0, ALU_SUM, 0, 0, 3'b101, 0), 1);
        drain();

        issue(32'hFC000000, ex(0, 0, 0, 0, 0, 0, 3'b101, 1), 1);
        drain();
        issue(rtype(1, 2, 3, 0, 6'd11), ex(0, 0, 0, 0, 0, 0, 3'b101, 1), 1);
        drain();

        preload(1, 32'd100); preload(2, 32'd200); preload(9, 32'h55);
        issue(rtype(1, 2, 9, 0, FN_ADD), none, 0);
        @(posedge clk); #1;
        chk("exec_alu_a", alu_a, 32'd100);
        rst_n = 1'b0;
        #1;
        reset_checks("abort");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_write", regs[9], 32'h55);
        chk("abort_flags", {29'd0, flags_q}, 32'd0);

        preload(10, 32'd10); preload(11, 32'd20);
        issue(rtype(10, 11, 12, 0, FN_ADD), ex(1, 12, 32'd30, ALU_SUM, 0, 0, 3'b000, 0), 1);
        t0 = cyc;
        issue(rtype(11, 10, 0, 0, FN_SUB), ex(0, 0, 32'd10, ALU_DIFF, 0, 0, 3'b000, 0), 1);
        t1 = cyc;
        issue(rtype(10, 11, 13, 0, FN_XOR), ex(1, 13, 32'd30, ALU_XOR, 0, 0, 3'b000, 0), 1);
        t2 = cyc;
        chk("b2b_gap1", t1 - t0, GAP);
        chk("b2b_gap2", t2 - t1, GAP);
        drain();
        chk("regfile_r13", regs[13], 32'd30);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
